controlador_carga_filas: RTL and testbench
==========================================

CONTROLADOR_CARGA_FILAS -- requirements
Module: controlador_carga_filas

Interface
REQ-001 Parameter ANCHO_PIXEL, default 8: pixel data width in bits.
REQ-002 Parameter ANCHO_IMAGEN, default 64: pixels per image row (>=2).
REQ-003 Parameter NUM_FILAS, default 3: window row slots; slot index is 2 bits wide.
REQ-004 Parameter ANCHO_DIR, default 12: memory address width.
REQ-005 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 iniciar_actualizacion  input  1  one-cycle request to load one row.
REQ-008 contar_fila  input  1  one-cycle request to advance the source row.
REQ-009 nuevo_cuadro  input  1  frame restart; clears all progress.
REQ-010 dato_mem  input  ANCHO_PIXEL  memory read data, valid 1 cycle after leer_mem.
REQ-011 leer_mem  output  1  memory read strobe.
REQ-012 dir_mem  output  ANCHO_DIR  memory read address.
REQ-013 escribir_fila  output  1  window row write strobe.
REQ-014 indice_fila  output  2  destination row slot, 0..NUM_FILAS-1.
REQ-015 columna  output  ANCHO_DIR  destination column, 0..ANCHO_IMAGEN-1.
REQ-016 dato_fila  output  ANCHO_PIXEL  pixel to write.
REQ-017 actualizacion_lista  output  1  one-cycle pulse when a row load completes.
REQ-018 filas_actualizadas  output  1  level; NUM_FILAS loads done since frame start.
REQ-019 ocupado  output  1  high in every state except E_REPOSO.

Function
REQ-020 The FSM SHALL have states E_REPOSO, E_LECTURA, E_ESPERA, E_FIN; unused encodings SHALL go to E_REPOSO.
REQ-021 E_REPOSO->E_LECTURA when iniciar_actualizacion=1. On that cycle, fila_origen SHALL capture base_fila, and slot SHALL capture the write pointer.
REQ-022 contar_fila SHALL be accepted only in E_REPOSO. When accepted, base_fila SHALL increase by ANCHO_IMAGEN modulo 2^ANCHO_DIR, with no multiplier.
REQ-023 contar_fila and iniciar_actualizacion in the same cycle: the load SHALL use base_fila before the increment.
REQ-024 In E_LECTURA, leer_mem=1 and dir_mem=fila_origen+k SHALL hold for k=0..ANCHO_IMAGEN-1 on consecutive cycles, then the FSM SHALL move to E_ESPERA.
REQ-025 escribir_fila, columna and dato_fila SHALL be leer_mem and k delayed one cycle, with dato_fila=dato_mem. The last write SHALL occur in E_ESPERA.
REQ-026 E_ESPERA->E_FIN unconditionally. E_FIN SHALL assert actualizacion_lista for exactly 1 cycle and then go to E_REPOSO.
REQ-027 Latency: request accepted at cycle t -> reads at t+1..t+W, writes at t+2..t+W+1, actualizacion_lista at t+W+2, back in E_REPOSO at t+W+3 (W=ANCHO_IMAGEN).
REQ-028 In E_FIN, the write pointer SHALL advance and wrap from NUM_FILAS-1 to 0. The load count SHALL increment and saturate at NUM_FILAS.
REQ-029 filas_actualizadas SHALL be registered, going high the cycle after the E_FIN in which the load count reaches NUM_FILAS. It SHALL stay high until nuevo_cuadro or reset.
REQ-030 iniciar_actualizacion or contar_fila outside E_REPOSO SHALL be ignored, with no queuing.
REQ-031 nuevo_cuadro SHALL act in any state and take priority over every other input. Next cycle: E_REPOSO; base_fila, write pointer and load count = 0; filas_actualizadas = 0.
REQ-032 nuevo_cuadro mid-load SHALL suppress the pending write and actualizacion_lista.
REQ-033 Outside read and write cycles, dir_mem, columna and dato_fila SHALL hold their last value. Strobes SHALL be 0.

Reset
REQ-034 Reset SHALL have the same effect as nuevo_cuadro and take priority over it.
REQ-035 Reset values SHALL be: state E_REPOSO, leer_mem=0, escribir_fila=0, actualizacion_lista=0, filas_actualizadas=0, ocupado=0, dir_mem=0, columna=0, dato_fila=0, indice_fila=0.
REQ-036 Reset asserted mid-load SHALL abort the load with no further strobes.

Verification (ANCHO_IMAGEN=4, NUM_FILAS=3, memory returns data = address)
REQ-037 Single load: iniciar+contar at t -> dir_mem 0,1,2,3 at t+1..t+4; writes indice_fila=0, col 0..3, data 0..3 at t+2..t+5; actualizacion_lista at t+6 only; ocupado low at t+7.
REQ-038 Three consecutive loads: second reads addresses 4..7 into slot 1, third reads 8..11 into slot 2. filas_actualizadas=1 the cycle after the third E_FIN; a fourth load writes slot 0 with addresses 12..15.
REQ-039 Request while busy: iniciar_actualizacion and contar_fila at t+2 of an active load -> no extra reads; the next load still uses base 4.
REQ-040 nuevo_cuadro at t+3 of a load -> no actualizacion_lista; the next load reads addresses 0..3 into slot 0; filas_actualizadas=0.
REQ-041 Reset at t+3 of a load -> all outputs at their reset values next cycle; leer_mem and escribir_fila stay 0 until a new request.

Source files
------------

// File: rtl/controlador_carga_filas.sv
// -----------------------------------------------------------------------------
// controlador_carga_filas
//
// Loads one image row from an external memory into one slot of a small
// window buffer (a set of NUM_FILAS row slots).  Each load request copies
// ANCHO_IMAGEN consecutive pixels, starting at the current source-row base
// address, into the slot selected by a rotating write pointer.  A separate
// request advances the source-row base by one image row.  A frame restart
// clears all progress.
//
// Parameters
//   ANCHO_PIXEL   pixel width in bits
//   ANCHO_IMAGEN  pixels per image row (>= 2)
//   NUM_FILAS     number of window row slots (slot index is 2 bits)
//   ANCHO_DIR     memory address width
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous, active-high reset
//   iniciar_actualizacion  one-cycle request to load one row (idle only)
//   contar_fila            one-cycle request to advance the source row (idle only)
//   nuevo_cuadro           frame restart, acts in any state
//   dato_mem               memory read data, valid one cycle after leer_mem
//   leer_mem / dir_mem     memory read strobe and address
//   escribir_fila          window row write strobe
//   indice_fila            destination slot of the write
//   columna                destination column of the write
//   dato_fila              pixel being written
//   actualizacion_lista    one-cycle pulse at the end of a row load
//   filas_actualizadas     level: NUM_FILAS loads completed since frame start
//   ocupado                high whenever a load is in progress
// -----------------------------------------------------------------------------
module controlador_carga_filas #(
  parameter int ANCHO_PIXEL  = 8,
  parameter int ANCHO_IMAGEN = 64,
  parameter int NUM_FILAS    = 3,
  parameter int ANCHO_DIR    = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iniciar_actualizacion,
  input  logic                   contar_fila,
  input  logic                   nuevo_cuadro,
  input  logic [ANCHO_PIXEL-1:0] dato_mem,
  output logic                   leer_mem,
  output logic [ANCHO_DIR-1:0]   dir_mem,
  output logic                   escribir_fila,
  output logic [1:0]             indice_fila,
  output logic [ANCHO_DIR-1:0]   columna,
  output logic [ANCHO_PIXEL-1:0] dato_fila,
  output logic                   actualizacion_lista,
  output logic                   filas_actualizadas,
  output logic                   ocupado
);

  typedef enum logic [1:0] {
    E_REPOSO  = 2'd0,
    E_LECTURA = 2'd1,
    E_ESPERA  = 2'd2,
    E_FIN     = 2'd3
  } estado_t;

  // Load counter must be able to hold NUM_FILAS itself (saturation value).
  localparam int ANCHO_CUENTA = $clog2(NUM_FILAS + 1);

  localparam logic [ANCHO_DIR-1:0]    PASO_FILA        = ANCHO_DIR'(ANCHO_IMAGEN);
  localparam logic [ANCHO_DIR-1:0]    ULTIMA_COLUMNA   = ANCHO_DIR'(ANCHO_IMAGEN - 1);
  localparam logic [ANCHO_DIR-1:0]    UNO_DIR          = ANCHO_DIR'(1);
  localparam logic [1:0]              ULTIMO_SLOT      = 2'(NUM_FILAS - 1);
  localparam logic [ANCHO_CUENTA-1:0] CUENTA_LLENA     = ANCHO_CUENTA'(NUM_FILAS);
  localparam logic [ANCHO_CUENTA-1:0] CUENTA_PENULTIMA = ANCHO_CUENTA'(NUM_FILAS - 1);
  localparam logic [ANCHO_CUENTA-1:0] UNO_CUENTA       = ANCHO_CUENTA'(1);

  estado_t                 estado;
  logic [ANCHO_DIR-1:0]    base_fila;       // start address of the current source row
  logic [ANCHO_DIR-1:0]    fila_origen;     // base_fila frozen for the load in progress
  logic [ANCHO_DIR-1:0]    indice_lectura;  // column k of the read being issued
  logic [1:0]              slot;            // destination slot frozen for the load
  logic [1:0]              puntero;         // next slot to be written
  logic [ANCHO_CUENTA-1:0] cuenta_cargas;   // completed loads, saturating
  logic [ANCHO_PIXEL-1:0]  dato_fila_q;     // last pixel written, held between writes

  // Control path.  Priority: reset, then nuevo_cuadro, then normal operation.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements see
  // values already modified in this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado              <= E_REPOSO;
      base_fila           <= '0;
      fila_origen         <= '0;
      indice_lectura      <= '0;
      slot                <= '0;
      puntero             <= '0;
      cuenta_cargas       <= '0;
      leer_mem            <= 1'b0;
      dir_mem             <= '0;
      escribir_fila       <= 1'b0;
      indice_fila         <= '0;
      columna             <= '0;
      actualizacion_lista <= 1'b0;
      filas_actualizadas  <= 1'b0;
      ocupado             <= 1'b0;
    end else if (nuevo_cuadro) begin
      // Abort any load in flight; address/column outputs keep their last value.
      estado              <= E_REPOSO;
      base_fila           <= '0;
      puntero             <= '0;
      cuenta_cargas       <= '0;
      leer_mem            <= 1'b0;
      escribir_fila       <= 1'b0;
      actualizacion_lista <= 1'b0;
      filas_actualizadas  <= 1'b0;
      ocupado             <= 1'b0;
    end else begin
      case (estado)
        E_REPOSO: begin
          leer_mem            <= 1'b0;
          escribir_fila       <= 1'b0;
          actualizacion_lista <= 1'b0;
          // Both requests in one cycle: the load captures the pre-increment base.
          if (contar_fila) begin
            base_fila <= base_fila + PASO_FILA;
          end
          if (iniciar_actualizacion) begin
            fila_origen    <= base_fila;
            slot           <= puntero;
            indice_lectura <= '0;
            dir_mem        <= base_fila;
            leer_mem       <= 1'b1;
            ocupado        <= 1'b1;
            estado         <= E_LECTURA;
          end else begin
            ocupado <= 1'b0;
          end
        end

        E_LECTURA: begin
          // The write lags the read by one cycle: column k is written while
          // its memory data is on dato_mem.
          escribir_fila <= 1'b1;
          columna       <= indice_lectura;
          indice_fila   <= slot;
          if (indice_lectura == ULTIMA_COLUMNA) begin
            leer_mem <= 1'b0;
            estado   <= E_ESPERA;
          end else begin
            indice_lectura <= indice_lectura + UNO_DIR;
            dir_mem        <= fila_origen + indice_lectura + UNO_DIR;
            leer_mem       <= 1'b1;
          end
        end

        E_ESPERA: begin
          // Last write of the row happens during this state.
          escribir_fila       <= 1'b0;
          actualizacion_lista <= 1'b1;
          estado              <= E_FIN;
        end

        E_FIN: begin
          actualizacion_lista <= 1'b0;
          ocupado             <= 1'b0;
          estado              <= E_REPOSO;
          puntero             <= (puntero == ULTIMO_SLOT) ? 2'd0 : puntero + 2'd1;
          if (cuenta_cargas != CUENTA_LLENA) begin
            cuenta_cargas <= cuenta_cargas + UNO_CUENTA;
          end
          if (cuenta_cargas >= CUENTA_PENULTIMA) begin
            filas_actualizadas <= 1'b1;
          end
        end

        default: begin
          estado              <= E_REPOSO;
          leer_mem            <= 1'b0;
          escribir_fila       <= 1'b0;
          actualizacion_lista <= 1'b0;
          ocupado             <= 1'b0;
        end
      endcase
    end
  end

  // Memory data arrives one cycle after the read, i.e. exactly in the write
  // cycle, so it is passed straight through while writing and the last
  // written pixel is held otherwise.  Captured even on nuevo_cuadro so the
  // held value is the one last presented to the window buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_fila_q <= '0;
    end else if (escribir_fila) begin
      dato_fila_q <= dato_mem;
    end
  end

  // NOTE: a continuous assign with both mux arms driven cannot infer a latch;
  // the hold behaviour comes from the dato_fila_q flop, not from the mux.
  assign dato_fila = escribir_fila ? dato_mem : dato_fila_q;

endmodule

// File: tb/tb_controlador_carga_filas.sv
// -----------------------------------------------------------------------------
// Bench for controlador_carga_filas (ANCHO_IMAGEN=4, NUM_FILAS=3).
// The memory returns data equal to the low bits of the address read on the
// previous cycle.  Expected outputs come from a schedule-based reference:
// an accepted request at cycle t lays out reads, writes and the done pulse
// at fixed offsets, and completion bookkeeping is applied afterwards.
// -----------------------------------------------------------------------------
module tb_controlador_carga_filas;

  localparam int AP = 8;
  localparam int W  = 4;
  localparam int NF = 3;
  localparam int AD = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar_actualizacion = 1'b0;
  logic          contar_fila = 1'b0;
  logic          nuevo_cuadro = 1'b0;
  logic [AP-1:0] dato_mem = '0;
  logic          leer_mem;
  logic [AD-1:0] dir_mem;
  logic          escribir_fila;
  logic [1:0]    indice_fila;
  logic [AD-1:0] columna;
  logic [AP-1:0] dato_fila;
  logic          actualizacion_lista;
  logic          filas_actualizadas;
  logic          ocupado;

  controlador_carga_filas #(
    .ANCHO_PIXEL (AP),
    .ANCHO_IMAGEN(W),
    .NUM_FILAS   (NF),
    .ANCHO_DIR   (AD)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .iniciar_actualizacion(iniciar_actualizacion),
    .contar_fila          (contar_fila),
    .nuevo_cuadro         (nuevo_cuadro),
    .dato_mem             (dato_mem),
    .leer_mem             (leer_mem),
    .dir_mem              (dir_mem),
    .escribir_fila        (escribir_fila),
    .indice_fila          (indice_fila),
    .columna              (columna),
    .dato_fila            (dato_fila),
    .actualizacion_lista  (actualizacion_lista),
    .filas_actualizadas   (filas_actualizadas),
    .ocupado              (ocupado)
  );

  always #5 clk = ~clk;

  // Memory: data = address, one cycle after the read strobe.
  always @(posedge clk) begin
    if (leer_mem) dato_mem <= dir_mem[AP-1:0];
  end

  int vectors = 0;
  int miscompares = 0;
  int ciclo = 0;

  task automatic check(input string nombre, input logic [31:0] actual,
                       input logic [31:0] esperado);
    vectors++;
    if (actual !== esperado) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nombre, actual, esperado, ciclo);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AD-1:0] m_base = '0;
  int            m_ptr = 0;
  int            m_cuenta = 0;
  bit            m_filas = 1'b0;
  bit            m_activa = 1'b0;
  int            m_e0 = 0;
  logic [AD-1:0] m_origen = '0;
  int            m_slot = 0;

  logic          x_leer = 1'b0, x_esc = 1'b0, x_lista = 1'b0, x_ocup = 1'b0;
  logic [AD-1:0] x_dir = '0, x_col = '0;
  logic [AP-1:0] x_dato = '0;
  logic [1:0]    x_idx = '0;

  // Called once per rising edge with the inputs that were present before it;
  // leaves the expected outputs for the cycle that follows the edge.
  task automatic modelo(input bit r, input bit i, input bit c, input bit n);
    int k;
    logic [AD-1:0] a;
    if (r) begin
      m_base = '0; m_ptr = 0; m_cuenta = 0; m_filas = 1'b0; m_activa = 1'b0;
      x_dir = '0; x_col = '0; x_dato = '0; x_idx = '0;
    end else if (n) begin
      m_base = '0; m_ptr = 0; m_cuenta = 0; m_filas = 1'b0; m_activa = 1'b0;
    end else if (!m_activa) begin
      if (i) begin
        m_activa = 1'b1; m_e0 = ciclo; m_origen = m_base; m_slot = m_ptr;
      end
      if (c) m_base = m_base + AD'(W);
    end
    // Bookkeeping becomes visible the cycle after the done pulse.
    if (m_activa && (ciclo - m_e0) == W + 2) begin
      m_ptr = (m_ptr + 1) % NF;
      if (m_cuenta < NF) m_cuenta++;
      if (m_cuenta == NF) m_filas = 1'b1;
      m_activa = 1'b0;
    end
    k = ciclo - m_e0;
    x_leer = m_activa && k < W;
    if (x_leer) x_dir = m_origen + AD'(k);
    x_esc = m_activa && k >= 1 && k <= W;
    if (x_esc) begin
      a      = m_origen + AD'(k - 1);
      x_col  = AD'(k - 1);
      x_dato = a[AP-1:0];
      x_idx  = 2'(m_slot);
    end
    x_lista = m_activa && k == W + 1;
    x_ocup  = m_activa;
  endtask

  // One clock cycle: drive inputs, let the edge happen, compare 1 ns later.
  task automatic tick(input bit r, input bit i, input bit c, input bit n);
    reset = r; iniciar_actualizacion = i; contar_fila = c; nuevo_cuadro = n;
    @(posedge clk);
    ciclo++;
    modelo(r, i, c, n);
    #1;
    check("m_leer_mem", leer_mem, x_leer);
    check("m_dir_mem", dir_mem, x_dir);
    check("m_escribir_fila", escribir_fila, x_esc);
    check("m_columna", columna, x_col);
    check("m_dato_fila", dato_fila, x_dato);
    check("m_indice_fila", indice_fila, x_idx);
    check("m_actualizacion_lista", actualizacion_lista, x_lista);
    check("m_filas_actualizadas", filas_actualizadas, m_filas);
    check("m_ocupado", ocupado, x_ocup);
  endtask

  // ---------------- directed table (single load after reset) ----------------
  typedef struct {
    bit            ini;
    bit            cnt;
    logic          leer;
    logic [AD-1:0] dir;
    logic          esc;
    logic [AD-1:0] col;
    logic [AP-1:0] dato;
    logic [1:0]    idx;
    logic          lista;
    logic          ocup;
    logic          filas;
  } vec_t;

  vec_t tabla [7];

  initial begin
    int lecturas;
    int pulsos;

    //           ini cnt leer dir esc col dato idx lista ocup filas
    tabla[0] = '{1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 12'd0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tabla[1] = '{1'b0, 1'b0, 1'b1, 12'd1, 1'b1, 12'd0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tabla[2] = '{1'b0, 1'b0, 1'b1, 12'd2, 1'b1, 12'd1, 8'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    tabla[3] = '{1'b0, 1'b0, 1'b1, 12'd3, 1'b1, 12'd2, 8'd2, 2'd0, 1'b0, 1'b1, 1'b0};
    tabla[4] = '{1'b0, 1'b0, 1'b0, 12'd3, 1'b1, 12'd3, 8'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    tabla[5] = '{1'b0, 1'b0, 1'b0, 12'd3, 1'b0, 12'd3, 8'd3, 2'd0, 1'b1, 1'b1, 1'b0};
    tabla[6] = '{1'b0, 1'b0, 1'b0, 12'd3, 1'b0, 12'd3, 8'd3, 2'd0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_ocupado", ocupado, 1'b0);
    check("rst_dir_mem", dir_mem, 12'd0);

    // Single load with simultaneous contar_fila.
    for (int v = 0; v < 7; v++) begin
      tick(1'b0, tabla[v].ini, tabla[v].cnt, 1'b0);
      check($sformatf("t%0d_leer", v), leer_mem, tabla[v].leer);
      check($sformatf("t%0d_dir", v), dir_mem, tabla[v].dir);
      check($sformatf("t%0d_esc", v), escribir_fila, tabla[v].esc);
      check($sformatf("t%0d_col", v), columna, tabla[v].col);
      check($sformatf("t%0d_dato", v), dato_fila, tabla[v].dato);
      check($sformatf("t%0d_idx", v), indice_fila, tabla[v].idx);
      check($sformatf("t%0d_lista", v), actualizacion_lista, tabla[v].lista);
      check($sformatf("t%0d_ocup", v), ocupado, tabla[v].ocup);
      check($sformatf("t%0d_filas", v), filas_actualizadas, tabla[v].filas);
    end

    // Loads 2..4: bases 4, 8, 12 into slots 1, 2, 0; filas after the third.
    for (int n = 1; n <= 3; n++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("carga%0d_dir0", n + 1), dir_mem, 32'(4 * n));
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("carga%0d_slot", n + 1), indice_fila, 32'(n % 3));
      repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("carga%0d_filas", n + 1), filas_actualizadas, (n >= 2) ? 32'd1 : 32'd0);
    end

    // Requests while busy are dropped.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    lecturas = 1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    if (leer_mem) lecturas++;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    if (leer_mem) lecturas++;
    repeat (5) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (leer_mem) lecturas++;
    end
    check("ocupado_lecturas", lecturas, 32'd4);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("ocupado_base_sig", dir_mem, 32'd4);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // nuevo_cuadro mid-load.
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("nuevo_ocupado", ocupado, 1'b0);
    pulsos = 0;
    repeat (6) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (actualizacion_lista) pulsos++;
    end
    check("nuevo_sin_lista", pulsos, 32'd0);
    check("nuevo_filas", filas_actualizadas, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("nuevo_dir0", dir_mem, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("nuevo_slot0", indice_fila, 2'd0);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-load.
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("rstmid_leer", leer_mem, 1'b0);
    check("rstmid_esc", escribir_fila, 1'b0);
    check("rstmid_dir", dir_mem, 12'd0);
    check("rstmid_col", columna, 12'd0);
    check("rstmid_dato", dato_fila, 8'd0);
    check("rstmid_idx", indice_fila, 2'd0);
    check("rstmid_ocup", ocupado, 1'b0);
    pulsos = 0;
    repeat (6) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (leer_mem || escribir_fila || actualizacion_lista) pulsos++;
    end
    check("rstmid_sin_strobes", pulsos, 32'd0);

    // Randomized traffic against the reference model.
    repeat (1500) begin
      tick(($urandom % 200) == 0, ($urandom % 100) < 25,
           ($urandom % 100) < 20, ($urandom % 100) < 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
